sobel_window: RTL

SOBEL_WINDOW -- requirements
Module: sobel_window

---
 rtl/sobel_window.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sobel_window.sv
// rtl/sobel_window.sv - 3x3 Sobel gradient window with two-stage magnitude pipeline
// Optional binarised output when SOBEL_THRESHOLD_EN is defined.
module sobel_window #(
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int THRESHOLD    = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] line0_in,
    input  logic [7:0] line1_in,
    input  logic [7:0] line2_in,
    input  logic       pixel_valid,
    output logic [7:0] edge_out,
    output logic       edge_valid,
    output logic       frame_done
);

    localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);

    logic [7:0]    win [3][3];
    logic [7:0]    nxt [3][3];
    logic [7:0]    col_in [3];
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;

    logic [9:0]  gx_pos, gx_neg, gy_pos, gy_neg;
    logic [10:0] gx, gy;
    logic        mask_in, last_in;

    logic [10:0] gx1, gy1;
    logic        v1, mask1, last1;

    logic [9:0]  ax, ay;
    logic [11:0] mag;
    logic [7:0]  sat;
    logic [7:0]  result;

    assign col_in[0] = line0_in;
    assign col_in[1] = line1_in;
    assign col_in[2] = line2_in;

    // Gradients are taken from the window as it will look after this shift,
    // so the incoming column feeds stage 1 directly and latency stays at two.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            nxt[r][0] = win[r][1];
            nxt[r][1] = win[r][2];
            nxt[r][2] = col_in[r];
        end
    end

    assign gx_pos = {2'b00, nxt[0][2]} + {1'b0, nxt[1][2], 1'b0} + {2'b00, nxt[2][2]};
    assign gx_neg = {2'b00, nxt[0][0]} + {1'b0, nxt[1][0], 1'b0} + {2'b00, nxt[2][0]};
    assign gy_pos = {2'b00, nxt[2][0]} + {1'b0, nxt[2][1], 1'b0} + {2'b00, nxt[2][2]};
    assign gy_neg = {2'b00, nxt[0][0]} + {1'b0, nxt[0][1], 1'b0} + {2'b00, nxt[0][2]};
    assign gx     = {1'b0, gx_pos} - {1'b0, gx_neg};
    assign gy     = {1'b0, gy_pos} - {1'b0, gy_neg};

    assign mask_in = (row_cnt < RW'(2)) || (col_cnt < CW'(2));
    assign last_in = (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= 8'd0;
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (pixel_valid) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= nxt[r][c];
            if (col_cnt == COL_LAST) begin
                col_cnt <= '0;
                row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + RW'(1);
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gx1   <= '0;
            gy1   <= '0;
            v1    <= 1'b0;
            mask1 <= 1'b0;
            last1 <= 1'b0;
        end else begin
            v1 <= pixel_valid;
            if (pixel_valid) begin
                gx1   <= gx;
                gy1   <= gy;
                mask1 <= mask_in;
                last1 <= last_in;
            end
        end
    end

    // Magnitudes never exceed 1020, so ten bits of the absolute value suffice.
    always_comb begin
        ax  = gx1[10] ? 10'(~gx1 + 11'd1) : gx1[9:0];
        ay  = gy1[10] ? 10'(~gy1 + 11'd1) : gy1[9:0];
        mag = {2'b00, ax} + {2'b00, ay};
        sat = (mag[11:8] != 4'd0) ? 8'hFF : mag[7:0];
    end

`ifdef SOBEL_THRESHOLD_EN
    localparam logic [8:0] THR = (THRESHOLD > 255) ? 9'd256 :
                                 (THRESHOLD < 0)   ? 9'd0   : 9'(THRESHOLD);
    assign result = ({1'b0, sat} >= THR) ? 8'hFF : 8'h00;
`else
    assign result = sat;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_out   <= 8'd0;
            edge_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            edge_valid <= v1;
            frame_done <= v1 && last1;
            if (v1)
                edge_out <= mask1 ? 8'd0 : result;
        end
    end

endmodule
